// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM states, ALU strobe indices,
// IR field positions and the per-cycle control bundle.
package alu_seq_pkg;

    localparam int NUM_REGS  = 16;
    localparam int OPC_W     = 5;
    localparam int REG_SEL_W = 4;
    localparam int ALU_OP_W  = 14;

    // IR field slice positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

    // alu_op bit indices, LSB first
    localparam int ALU_INCPC = 0;
    localparam int ALU_ADD   = 1;
    localparam int ALU_SUB   = 2;
    localparam int ALU_AND   = 3;
    localparam int ALU_OR    = 4;
    localparam int ALU_SHR   = 5;
    localparam int ALU_SHRA  = 6;
    localparam int ALU_SHL   = 7;
    localparam int ALU_ROR   = 8;
    localparam int ALU_ROL   = 9;
    localparam int ALU_NEG   = 10;
    localparam int ALU_NOT   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_DIV   = 13;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic                 r_in_en;
        logic [REG_SEL_W-1:0] r_in_sel;
        logic                 r_out_en;
        logic [REG_SEL_W-1:0] r_out_sel;
        logic                 pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in;
        logic                 pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out;
        logic                 read;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 illegal_op;
    } ctrl_t;

    function automatic op_class_e classify(input logic [OPC_W-1:0] op);
        op_class_e cls;
        case (op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
            OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL:        cls = CLS_BINARY;
            OPC_MUL, OPC_DIV:                           cls = CLS_MULDIV;
            OPC_NEG, OPC_NOT:                           cls = CLS_UNARY;
            OPC_NOP:                                    cls = CLS_NOP;
            OPC_HALT:                                   cls = CLS_HALT;
            default:                                    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_onehot(input logic [OPC_W-1:0] op);
        logic [ALU_OP_W-1:0] v;
        v = '0;
        case (op)
            OPC_ADD:  v[ALU_ADD]  = 1'b1;
            OPC_SUB:  v[ALU_SUB]  = 1'b1;
            OPC_AND:  v[ALU_AND]  = 1'b1;
            OPC_OR:   v[ALU_OR]   = 1'b1;
            OPC_SHR:  v[ALU_SHR]  = 1'b1;
            OPC_SHRA: v[ALU_SHRA] = 1'b1;
            OPC_SHL:  v[ALU_SHL]  = 1'b1;
            OPC_ROR:  v[ALU_ROR]  = 1'b1;
            OPC_ROL:  v[ALU_ROL]  = 1'b1;
            OPC_NEG:  v[ALU_NEG]  = 1'b1;
            OPC_NOT:  v[ALU_NOT]  = 1'b1;
            OPC_MUL:  v[ALU_MUL]  = 1'b1;
            OPC_DIV:  v[ALU_DIV]  = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Sequencer <-> datapath signal bundle. master = sequencer, slave = datapath.
// ALU_SEQ_ICOUNT_EN adds the retired-instruction counter output.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic                run;
    logic                mem_ready;
    logic [31:0]         ir;
    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic                pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in;
    logic                pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out;
    logic                read;
    logic [ALU_OP_W-1:0] alu_op;
    logic                halted;
    logic                illegal_op;
`ifdef ALU_SEQ_ICOUNT_EN
    logic [31:0]         instr_count;

    modport master (
        input  run, mem_ready, ir,
        output r_in, r_out, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
        output pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out,
        output read, alu_op, halted, illegal_op, instr_count
    );
    modport slave (
        output run, mem_ready, ir,
        input  r_in, r_out, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
        input  pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out,
        input  read, alu_op, halted, illegal_op, instr_count
    );
`else
    modport master (
        input  run, mem_ready, ir,
        output r_in, r_out, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
        output pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out,
        output read, alu_op, halted, illegal_op
    );
    modport slave (
        output run, mem_ready, ir,
        input  r_in, r_out, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
        input  pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out,
        input  read, alu_op, halted, illegal_op
    );
`endif
endinterface

// File: rtl/reg_sel_decoder.sv
// Turns a register-select field plus enable into a one-hot register strobe vector.
module reg_sel_decoder #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 16
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] onehot_o
);
    // NOTE: assign a default before any conditional write so no latch is inferred.
    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[sel_i] = 1'b1;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/decode/execute control unit for the Phase-1 datapath.
// Define ALU_SEQ_ICOUNT_EN to add the instr_count retired-instruction counter.
module alu_op_sequencer (
    input logic                clock,
    input logic                clear,
    alu_op_sequencer_if.master seq
);
    import alu_seq_pkg::*;

    state_e              state_q, state_d;
    logic                halted_q, halted_d;
    ctrl_t               ctrl;
    logic [OPC_W-1:0]    opc;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    op_class_e           op_cls;
    logic [ALU_OP_W-1:0] alu_sel;

    assign opc     = seq.ir[OP_MSB:OP_LSB];
    assign ra      = seq.ir[RA_MSB:RA_LSB];
    assign rb      = seq.ir[RB_MSB:RB_LSB];
    assign rc      = seq.ir[RC_MSB:RC_LSB];
    assign op_cls  = classify(opc);
    assign alu_sel = alu_onehot(opc);

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: if (seq.run && !halted_q) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (seq.mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_cls == CLS_HALT) halted_d = 1'b1;
                if (op_cls inside {CLS_BINARY, CLS_MULDIV, CLS_UNARY}) state_d = ST_T4;
                else                                                  state_d = ST_IDLE;
            end
            ST_T4:   state_d = (op_cls inside {CLS_BINARY, CLS_MULDIV}) ? ST_T5 : ST_IDLE;
            ST_T5:   state_d = (op_cls == CLS_MULDIV) ? ST_T6 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Strobes decode from the current state and the live IR, so T3 sees the word loaded in T2.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_T0: begin
                ctrl.pc_out            = 1'b1;
                ctrl.mar_in            = 1'b1;
                ctrl.alu_op[ALU_INCPC] = 1'b1;
                ctrl.z_in              = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
                ctrl.pc_in    = seq.mem_ready;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (op_cls)
                    CLS_BINARY: begin
                        ctrl.r_out_en = 1'b1; ctrl.r_out_sel = rb; ctrl.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.r_out_en = 1'b1; ctrl.r_out_sel = ra; ctrl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.r_out_en = 1'b1; ctrl.r_out_sel = rb;
                        ctrl.alu_op   = alu_sel; ctrl.z_in = 1'b1;
                    end
                    CLS_ILLEGAL: ctrl.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_cls)
                    CLS_BINARY: begin
                        ctrl.r_out_en = 1'b1; ctrl.r_out_sel = rc;
                        ctrl.alu_op   = alu_sel; ctrl.z_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.r_out_en = 1'b1; ctrl.r_out_sel = rb;
                        ctrl.alu_op   = alu_sel; ctrl.z_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.r_in_en = 1'b1; ctrl.r_in_sel = ra;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_cls)
                    CLS_BINARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.r_in_en = 1'b1; ctrl.r_in_sel = ra;
                    end
                    CLS_MULDIV: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                ctrl.zhigh_out = 1'b1;
                ctrl.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decoder #(.SEL_W(REG_SEL_W), .OUT_W(NUM_REGS)) u_r_in_dec (
        .sel_i    (ctrl.r_in_sel),
        .en_i     (ctrl.r_in_en),
        .onehot_o (seq.r_in)
    );

    reg_sel_decoder #(.SEL_W(REG_SEL_W), .OUT_W(NUM_REGS)) u_r_out_dec (
        .sel_i    (ctrl.r_out_sel),
        .en_i     (ctrl.r_out_en),
        .onehot_o (seq.r_out)
    );

    assign seq.pc_in      = ctrl.pc_in;
    assign seq.ir_in      = ctrl.ir_in;
    assign seq.y_in       = ctrl.y_in;
    assign seq.z_in       = ctrl.z_in;
    assign seq.mar_in     = ctrl.mar_in;
    assign seq.mdr_in     = ctrl.mdr_in;
    assign seq.hi_in      = ctrl.hi_in;
    assign seq.lo_in      = ctrl.lo_in;
    assign seq.pc_out     = ctrl.pc_out;
    assign seq.mdr_out    = ctrl.mdr_out;
    assign seq.zhigh_out  = ctrl.zhigh_out;
    assign seq.zlow_out   = ctrl.zlow_out;
    assign seq.hi_out     = ctrl.hi_out;
    assign seq.lo_out     = ctrl.lo_out;
    assign seq.read       = ctrl.read;
    assign seq.alu_op     = ctrl.alu_op;
    assign seq.illegal_op = ctrl.illegal_op;
    assign seq.halted     = halted_q;

`ifdef ALU_SEQ_ICOUNT_EN
    logic [31:0] count_q, count_d;
    logic        retire;

    // Retire on the last execute step of each ALU-using instruction.
    assign retire = ((state_q == ST_T5) && (op_cls == CLS_BINARY)) ||
                    ((state_q == ST_T6) && (op_cls == CLS_MULDIV)) ||
                    ((state_q == ST_T4) && (op_cls == CLS_UNARY));
    assign count_d = retire ? count_q + 32'd1 : count_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) count_q <= '0;
        else        count_q <= count_d;
    end

    assign seq.instr_count = count_q;
`else
`endif

endmodule
